bcd2bin: RTL
============

Name: bcd2bin

Overview:
- Sequential BCD-to-binary converter; the inverse of the display path's binary-to-BCD conversion.
- Takes a packed 8-digit BCD frequency/period value and a 2-digit BCD duty value from the user-entry logic (keypad/UI digit registers).
- Produces the binary values consumed by the measurement/compare logic.
- Uses an MSD-first multiply-by-10-and-add, one digit per clock, with a start/busy/done handshake.

Parameters:
- DIGITS, 8, number of BCD digits in the main value.
- BIN_W, 28, width of the binary result. Requires 10^DIGITS-1 < 2^BIN_W.

Ports:
- clk_50M  input  1  system clock, 50 MHz, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- number  input  4*DIGITS  packed BCD value; digit 0 in [3:0], MSD in the top nibble.
- duty_number  input  8  packed 2-digit BCD duty; tens in [7:4], ones in [3:0].
- bin  output  BIN_W  binary result of number.
- duty_bin  output  7  binary result of duty_number, 0..99.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse when bin/duty_bin are updated.
- err  output  1  set if any input nibble was >9 in the last conversion.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; bin=0, duty_bin=0, busy=0, done=0, err=0; internal accumulators, shift registers and digit counter cleared.
- Reset asserted mid-conversion aborts it. No done pulse is produced, and outputs return to 0.
- States:
  - IDLE: busy=0. On a clock edge with start=1:
    - latch number and duty_number into internal shift registers;
    - clear acc and duty_acc; cnt=0;
    - set an internal bad flag if any of the DIGITS+2 nibbles is >9;
    - go to CONV; busy=1 from this edge.
  - CONV: each edge:
    - acc <= acc*10 + top nibble of the main shift register; shift register <<4; cnt++;
    - during the first 2 CONV edges, duty_acc <= duty_acc*10 + top duty nibble, and the duty shift register <<4;
    - on the edge where cnt reaches DIGITS (the DIGITS-th CONV edge): load bin and duty_bin, pulse done=1, set err=bad, busy=0, go to IDLE.
- Latency: start sampled at edge E0; done/bin valid immediately after edge E0+DIGITS (8 clocks). The earliest next start is sampled at E0+DIGITS+1, so back-to-back throughput is one conversion per DIGITS+1 clocks.
- Arithmetic: acc*10 is formed as (acc<<3)+(acc<<1) in BIN_W+4 bits and truncated to BIN_W. With valid digits no truncation occurs. duty_acc is 7 bits (max 99).
- Invalid digit (bad=1):
  - the conversion still runs the full DIGITS cycles, so timing stays deterministic;
  - bin and duty_bin are loaded with 0, err=1, and done still pulses.
- err holds until the next conversion completes; a valid conversion clears it. err changes only at done or reset.
- start while busy is ignored; there is no queueing.
- number/duty_number changing during CONV does not affect the result, because inputs are latched at start.
- done is high for exactly one cycle. bin and duty_bin hold their value between conversions.
- Simultaneous start and done edge: not possible, since start is sampled only in IDLE. start held high continuously re-converts every DIGITS+1 cycles.

Test Plan:
- number=32'h12345678, duty_number=8'h50, start 1 cycle -> exactly 8 clocks later done=1 for 1 cycle, bin=12345678 (28'h0BC614E), duty_bin=50, err=0, busy high for the 8 cycles.
- number=32'h99999999, duty_number=8'h99 -> bin=99999999 (28'h5F5E0FF), duty_bin=99, err=0. number=0, duty_number=0 -> bin=0, duty_bin=0, done still pulses.
- number=32'h0000000A (one nibble >9) -> done after 8 clocks, bin=0, duty_bin=0, err=1. Then a valid conversion of 32'h00000042 -> bin=42, err=0.
- Start 32'h00001000, then change number to 32'h77777777 and pulse start again at cycle 3 -> single done after 8 clocks, bin=1000; the second start is ignored (no second done).
- Assert rst low at CONV cycle 4 -> all outputs 0 immediately, no done. Release reset, start 32'h00000500 -> bin=500 after 8 clocks.
- 1000 random valid values, chained with the existing binary-to-BCD block (bin -> BCD -> this block) -> bin equals the original value and duty_bin equals the original duty every time.

Source files
------------

// File: rtl/bcd2bin_if.sv
// Handshake/data bundle between the user-entry digit registers and bcd2bin.
// master drives the BCD request; slave returns the binary result and status.
interface bcd2bin_if #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned BIN_W  = 28
);
    logic                  start;
    logic [4*DIGITS-1:0]   number;
    logic [7:0]            duty_number;
    logic [BIN_W-1:0]      bin;
    logic [6:0]            duty_bin;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, number, duty_number,
        input  bin, duty_bin, busy, done, err
    );

    modport slave (
        input  start, number, duty_number,
        output bin, duty_bin, busy, done, err
    );
endinterface

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter: MSD-first acc*10+digit, one digit per clock.
// A DIGITS-digit main value and a 2-digit duty value convert in the same DIGITS-cycle pass.
module bcd2bin #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned BIN_W  = 28
) (
    input  logic      clk_50M,
    input  logic      rst,
    bcd2bin_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state_q;
    logic [4*DIGITS-1:0] num_sr_q;
    logic [7:0]          duty_sr_q;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [6:0]          duty_acc_q, duty_acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                bad_q, in_bad;
    logic [BIN_W-1:0]    bin_q;
    logic [6:0]          duty_bin_q;
    logic                busy_q, done_q, err_q;

    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.number[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
        if (bus.duty_number[3:0] > 4'd9 || bus.duty_number[7:4] > 4'd9) in_bad = 1'b1;
    end

    // x10 as (x<<3)+(x<<1) with 4 bits of headroom, then truncated back
    always_comb begin
        acc_d = BIN_W'(({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                       + {{BIN_W{1'b0}}, num_sr_q[4*DIGITS-1 -: 4]});
        duty_acc_d = 7'(({4'b0000, duty_acc_q} << 3) + ({4'b0000, duty_acc_q} << 1)
                        + {7'b0000000, duty_sr_q[7:4]});
    end

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            num_sr_q   <= '0;
            duty_sr_q  <= '0;
            acc_q      <= '0;
            duty_acc_q <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            bin_q      <= '0;
            duty_bin_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        num_sr_q   <= bus.number;
                        duty_sr_q  <= bus.duty_number;
                        acc_q      <= '0;
                        duty_acc_q <= '0;
                        cnt_q      <= '0;
                        bad_q      <= in_bad;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    acc_q    <= acc_d;
                    num_sr_q <= num_sr_q << 4;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q < CNT_W'(2)) begin
                        duty_acc_q <= duty_acc_d;
                        duty_sr_q  <= duty_sr_q << 4;
                    end
                    // Last digit: results come straight from the next-value path
                    if (cnt_q == CNT_W'(DIGITS - 1)) begin
                        bin_q      <= bad_q ? '0 : acc_d;
                        duty_bin_q <= bad_q ? '0 : duty_acc_q;
                        err_q      <= bad_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bin      = bin_q;
    assign bus.duty_bin = duty_bin_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
